// File: rtl/alu_seq_hs_pkg.sv
// Shared opcode and FSM definitions for the handshaked sequential ALU.
// Imported by the top level and the iterative multiplier.
package alu_seq_hs_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_NEG  = 4'd0;
  localparam logic [OPC_W-1:0] OP_INC  = 4'd1;
  localparam logic [OPC_W-1:0] OP_ADC  = 4'd2;
  localparam logic [OPC_W-1:0] OP_ADDH = 4'd3;
  localparam logic [OPC_W-1:0] OP_AND  = 4'd4;
  localparam logic [OPC_W-1:0] OP_OR   = 4'd5;
  localparam logic [OPC_W-1:0] OP_PACK = 4'd6;
  localparam logic [OPC_W-1:0] OP_ZERO = 4'd7;
  localparam logic [OPC_W-1:0] OP_MUL  = 4'd8;
  localparam logic [OPC_W-1:0] OP_SHL  = 4'd9;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  // Opcodes 0-3 share the WIDTH+1 bit adder and its carry/overflow flags.
  function automatic logic isAddOp(input logic [OPC_W-1:0] op);
    return op <= OP_ADDH;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH steps.
// done_o is raised during the final step; prod_o then already includes that step.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic               busy_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;

  assign acc_d  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign done_o = busy_q && (cnt_q == CW'(1));
  assign prod_o = acc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= CW'(WIDTH);
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
      busy_q   <= (cnt_q != CW'(1));
    end
  end

endmodule

// File: rtl/alu_seq_hs.sv
// Registered ALU with valid/ready on both sides: single-cycle ops complete at the
// accept edge, MUL runs through the iterative multiplier before loading the output.
module alu_seq_hs
  import alu_seq_hs_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             inC,
  input  logic [OPC_W-1:0] opc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] outW,
  output logic             zer,
  output logic             neg,
  output logic             cout,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t             state_q;
  logic               valid_q;
  logic [WIDTH-1:0]   res_q;
  logic               zer_q;
  logic               neg_q;
  logic               cout_q;
  logic               ovf_q;

  logic               accept;
  logic               mulStart;
  logic               mulDone;
  logic [2*WIDTH-1:0] mulProd;

  logic [WIDTH-1:0]   addOp1;
  logic [WIDTH-1:0]   addOp2;
  logic               addCin;
  logic [WIDTH:0]     addSum;
  logic               addOvf;
  logic [WIDTH:0]     shlExt;

  logic [WIDTH-1:0]   res_d;
  logic               cout_d;
  logic               ovf_d;

  assign in_ready = (state_q == S_IDLE) && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign mulStart = accept && (opc == OP_MUL);

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start_i (mulStart),
    .a_i     (inA),
    .b_i     (inB),
    .done_o  (mulDone),
    .prod_o  (mulProd)
  );

  // Operand selection for the shared adder; NEG is ~A + 1, INC is A + 1.
  always_comb begin
    addOp1 = inA;
    addOp2 = inB;
    addCin = 1'b0;
    case (opc)
      OP_NEG: begin
        addOp1 = ~inA;
        addOp2 = ONE;
      end
      OP_INC:  addOp2 = ONE;
      OP_ADC:  addCin = inC;
      OP_ADDH: addOp2 = {inB[WIDTH-1], inB[WIDTH-1:1]};
      default: ;
    endcase
  end

  assign addSum = {1'b0, addOp1} + {1'b0, addOp2} + {{WIDTH{1'b0}}, addCin};
  assign addOvf = (addOp1[WIDTH-1] == addOp2[WIDTH-1]) &&
                  (addSum[WIDTH-1] != addOp1[WIDTH-1]);

  // The extra top bit catches the last bit shifted out; it stays 0 for a zero shift.
  assign shlExt = {1'b0, inA} << inB[SHW-1:0];

  always_comb begin
    res_d  = '0;
    cout_d = 1'b0;
    ovf_d  = 1'b0;
    if (isAddOp(opc)) begin
      res_d  = addSum[WIDTH-1:0];
      cout_d = addSum[WIDTH];
      ovf_d  = addOvf;
    end else begin
      case (opc)
        OP_AND:  res_d = inA & inB;
        OP_OR:   res_d = inA | inB;
        OP_PACK: res_d = {inA[WIDTH/2-1:0], inB[WIDTH/2-1:0]};
        OP_SHL: begin
          res_d  = shlExt[WIDTH-1:0];
          cout_d = shlExt[WIDTH];
        end
        default: ;
      endcase
    end
  end

  // Control FSM and output register; results hold while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      res_q   <= '0;
      zer_q   <= 1'b0;
      neg_q   <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (opc == OP_MUL) begin
              state_q <= S_MUL;
              valid_q <= 1'b0;
            end else begin
              valid_q <= 1'b1;
              res_q   <= res_d;
              zer_q   <= (res_d == '0);
              neg_q   <= res_d[WIDTH-1];
              cout_q  <= cout_d;
              ovf_q   <= ovf_d;
            end
          end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
          end
        end
        S_MUL: begin
          if (mulDone) begin
            state_q <= S_IDLE;
            valid_q <= 1'b1;
            res_q   <= mulProd[WIDTH-1:0];
            zer_q   <= (mulProd[WIDTH-1:0] == '0);
            neg_q   <= mulProd[WIDTH-1];
            cout_q  <= 1'b0;
            ovf_q   <= |mulProd[2*WIDTH-1:WIDTH];
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = valid_q;
  assign outW      = res_q;
  assign zer       = zer_q;
  assign neg       = neg_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_seq_hs.sv
// Scoreboard bench for alu_seq_hs (WIDTH=16): directed cases, back-pressure,
// streaming and randomized traffic checked against an arithmetic reference model.
module tb_alu_seq_hs;

  typedef struct packed {
    logic [15:0] w;
    logic [3:0]  f;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] inA;
  logic [15:0] inB;
  logic        inC;
  logic [3:0]  opc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] outW;
  logic        zer;
  logic        neg;
  logic        cout;
  logic        ovf;

  int   total = 0;
  int   bad = 0;
  int   cycle = 0;
  exp_t sbQ[$];

  alu_seq_hs #(
    .WIDTH (16),
    .SHW   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inA       (inA),
    .inB       (inB),
    .inC       (inC),
    .opc       (opc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .outW      (outW),
    .zer       (zer),
    .neg       (neg),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Reference model: plain integer arithmetic; flags packed as {zer, neg, cout, ovf}.
  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic c);
    exp_t               e;
    logic [15:0]        x;
    logic [15:0]        y;
    logic signed [15:0] bs;
    int unsigned        full;
    int unsigned        cin;
    int                 sgn;
    logic [31:0]        wide;
    e = '0;
    if (op <= 4'd3) begin
      x   = (op == 4'd0) ? ~a : a;
      y   = (op <= 4'd1) ? 16'd1 : b;
      cin = (op == 4'd2) ? int'(c) : 0;
      if (op == 4'd3) begin
        bs = b;
        y  = bs >>> 1;
      end
      full   = x + y + cin;
      sgn    = int'($signed(x)) + int'($signed(y)) + int'(cin);
      e.w    = full[15:0];
      e.f[1] = full[16];
      e.f[0] = (sgn > 32767) || (sgn < -32768);
    end else begin
      case (op)
        4'd4: e.w = a & b;
        4'd5: e.w = a | b;
        4'd6: e.w = {a[7:0], b[7:0]};
        4'd8: begin
          wide   = a * b;
          e.w    = wide[15:0];
          e.f[0] = (wide[31:16] != 16'd0);
        end
        4'd9: begin
          wide   = {16'h0, a} << b[3:0];
          e.w    = wide[15:0];
          e.f[1] = wide[16];
        end
        default: e.w = 16'h0;
      endcase
    end
    e.f[3] = (e.w == 16'h0);
    e.f[2] = e.w[15];
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: pops the oldest expectation on every output transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_output", {16'h0, outW}, 32'hDEAD_BEEF);
        end else begin
          e = sbQ.pop_front();
          checkOutput("scoreboard", {12'h0, outW, zer, neg, cout, ovf}, {12'h0, e.w, e.f});
        end
      end
    end
  end

  // Must be called just after a rising edge; returns just after the accept edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a,
                               input logic [15:0] b, input logic c, input bit bp);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    opc      = op;
    inA      = a;
    inB      = b;
    inC      = c;
    for (int k = 0; k < 80 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sbQ.push_back(model(op, a, b, c));
        done = 1'b1;
      end else if (bp) begin
        @(posedge clk);
        #1 out_ready = ($urandom_range(0, 1) == 1);
      end
    end
    if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    inA      = $urandom();
    inB      = $urandom();
  endtask

  task automatic runDirect(input string name, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic c, input logic [15:0] expW,
                           input logic [3:0] expF, input int expLat);
    int lat;
    int readyCnt;
    lat      = -1;
    readyCnt = 0;
    applyStimulus(op, a, b, c, 1'b0);
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge clk);
      if (out_valid) lat = i + 1;
      else if (in_ready) readyCnt++;
    end
    checkOutput({name, "_latency"}, lat, expLat);
    checkOutput({name, "_busy_ready"}, readyCnt, 0);
    checkOutput({name, "_outW"}, {16'h0, outW}, {16'h0, expW});
    checkOutput({name, "_flags"}, {28'h0, zer, neg, cout, ovf}, {28'h0, expF});
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, "_out_valid"}, {31'h0, out_valid}, 32'd0);
    checkOutput({name, "_outW"}, {16'h0, outW}, 32'd0);
    checkOutput({name, "_flags"}, {28'h0, zer, neg, cout, ovf}, 32'd0);
    checkOutput({name, "_in_ready"}, {31'h0, in_ready}, 32'd1);
  endtask

  initial begin
    int startCyc;
    int strayValid;
    rst       = 1'b1;
    in_valid  = 1'b0;
    inA       = 16'h0;
    inB       = 16'h0;
    inC       = 1'b0;
    opc       = 4'd0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkResetState("reset");
    @(posedge clk);
    #1;

    // Reset in the middle of a multiply must abort it without a result.
    applyStimulus(4'd8, 16'h1234, 16'h5678, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sbQ.delete();
    @(negedge clk);
    checkResetState("mid_mul_reset");
    strayValid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) strayValid++;
    end
    checkOutput("aborted_mul_output", strayValid, 0);
    @(posedge clk);
    #1;

    runDirect("adc_carry", 4'd2, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 4'b1010, 1);
    runDirect("adc_ovf",   4'd2, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b0101, 1);
    runDirect("neg",       4'd0, 16'h0001, 16'h0000, 1'b0, 16'hFFFF, 4'b0100, 1);
    runDirect("pack",      4'd6, 16'h12AB, 16'h34CD, 1'b0, 16'hABCD, 4'b0100, 1);
    runDirect("addh",      4'd3, 16'h0010, 16'hFFFE, 1'b0, 16'h000F, 4'b0010, 1);
    runDirect("mul_ovf",   4'd8, 16'h0100, 16'h0100, 1'b0, 16'h0000, 4'b1001, 17);
    runDirect("mul",       4'd8, 16'h00FF, 16'h0003, 1'b0, 16'h02FD, 4'b0000, 17);
    runDirect("shl",       4'd9, 16'h8001, 16'h0001, 1'b0, 16'h0002, 4'b0010, 1);
    runDirect("shl_zero",  4'd9, 16'h8001, 16'h0010, 1'b0, 16'h8001, 4'b0100, 1);
    runDirect("reserved",  4'd12, 16'h1234, 16'h5678, 1'b1, 16'h0000, 4'b1000, 1);

    // Back-pressure: the AND result must hold while a queued OR waits.
    out_ready = 1'b0;
    applyStimulus(4'd4, 16'hF0F0, 16'hFF00, 1'b0, 1'b0);
    fork
      applyStimulus(4'd5, 16'hF0F0, 16'h0F0F, 1'b0, 1'b0);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          checkOutput("bp_valid", {31'h0, out_valid}, 32'd1);
          checkOutput("bp_hold_outW", {16'h0, outW}, 32'h0000_F000);
          checkOutput("bp_in_ready", {31'h0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    @(negedge clk);
    checkOutput("bp_next_valid", {31'h0, out_valid}, 32'd1);
    checkOutput("bp_next_outW", {16'h0, outW}, 32'h0000_FFFF);
    @(posedge clk);
    #1;

    // Streaming: one INC accepted per cycle with the consumer always ready.
    startCyc = cycle;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'd1, 16'($urandom()), 16'($urandom()), 1'b0, 1'b0);
    end
    checkOutput("stream_cycles", cycle - startCyc, 8);

    for (int i = 0; i < 120; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      applyStimulus(4'($urandom_range(0, 15)), 16'($urandom()), 16'($urandom()),
                    1'($urandom_range(0, 1)), 1'b1);
    end

    out_ready = 1'b1;
    for (int i = 0; i < 100 && sbQ.size() != 0; i++) @(negedge clk);
    checkOutput("drain_pending", sbQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
